soc_system_led_sequencer: RTL and testbench

Autonomous pattern engine for the board LED bank. Holds a small Avalon-MM configuration slave for the HPS, generates a divided time base, and acts as an Avalon-MM write master that updates the LED PIO data register (offset 0) once per programmed period. Sits between the lightweight HPS bridge and the LED PIO's s1 port, so software sets the mode once instead of bit-banging the LEDs.

---
 rtl/soc_system_led_seq_pkg.sv | 26 ++
 rtl/soc_system_led_seq_tick.sv | 31 +++
 rtl/soc_system_led_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_soc_system_led_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_led_seq_pkg.sv
// soc_system_led_seq_pkg: encodings and reset constants shared by the LED
// sequencer top and its tick prescaler.
package soc_system_led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PERIOD  = 2'd1;
    localparam logic [1:0] REG_PATTERN = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam int unsigned PERIOD_RST  = 250;
    localparam int unsigned PATTERN_RST = 15;

endpackage

// File: rtl/soc_system_led_seq_tick.sv
// soc_system_led_seq_tick: TICK_DIV prescaler producing a one-cycle tick.
// Held at count 0 while clear is high so each sequence starts on a fresh phase.
module soc_system_led_seq_tick #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);
    import soc_system_led_seq_pkg::*;

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running divider, wraps at TICK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/soc_system_led_sequencer.sv
// soc_system_led_sequencer: autonomous LED pattern engine. Config slave for
// the HPS, tick prescaler, and an Avalon-MM write master updating the LED PIO
// data register once per programmed period.
// Optional build macro: LED_SEQ_BOUNCE_EN enables MODE 2 bounce and the DIR
// register; without it MODE 2 behaves as static and STATUS bit1 reads 0.
module soc_system_led_sequencer #(
    parameter int unsigned LED_WIDTH = 10,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned PERIOD_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  cfg_address,
    input  logic        cfg_chipselect,
    input  logic        cfg_write_n,
    input  logic [31:0] cfg_writedata,
    output logic [31:0] cfg_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);
    import soc_system_led_seq_pkg::*;

    logic                 ctrl_en;
    mode_t                ctrl_mode;
    logic [PERIOD_W-1:0]  period;
    logic [LED_WIDTH-1:0] pattern;
    state_t               state;
    state_t               state_nxt;
    logic [PERIOD_W-1:0]  per_cnt;
    logic [PERIOD_W-1:0]  cnt_nxt;
    logic [PERIOD_W-1:0]  per_last;
    logic [LED_WIDTH-1:0] pat_nxt;
    logic [LED_WIDTH-1:0] step_pat;
    logic                 step_write;
    logic                 pend;
    logic                 pend_nxt;
    logic                 tick;
    logic                 cfg_wr;
    logic                 ctrl_wr;
    logic                 pat_wr;
    logic                 en_nxt;
    logic                 en_rise;
    logic                 do_step;
    logic                 load_wd;
    logic [31:0]          wd_nxt;
    logic                 dir_bit;
    logic                 cfg_wdata_unused;

`ifdef LED_SEQ_BOUNCE_EN
    logic dir;
    logic step_dir;
    assign dir_bit = dir;
`else
    assign dir_bit = 1'b0;
`endif

    assign cfg_wr   = cfg_chipselect && !cfg_write_n;
    assign ctrl_wr  = cfg_wr && (cfg_address == REG_CTRL);
    assign pat_wr   = cfg_wr && (cfg_address == REG_PATTERN);
    assign en_nxt   = ctrl_wr ? cfg_writedata[0] : ctrl_en;
    assign en_rise  = ctrl_wr && cfg_writedata[0] && !ctrl_en;
    assign per_last = (period == '0) ? '0 : period - 1'b1;
    // >= rather than == so a PERIOD shrunk below the running count still fires on the next tick.
    assign do_step  = (state == WAIT) && en_nxt && tick && (per_cnt >= per_last);

    assign cfg_wdata_unused = ^cfg_writedata;

    soc_system_led_seq_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    // Configuration registers; PATTERN lives with the sequencer state below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_STATIC;
            period    <= PERIOD_W'(PERIOD_RST);
        end else if (cfg_wr) begin
            if (cfg_address == REG_CTRL) begin
                ctrl_en   <= cfg_writedata[0];
                ctrl_mode <= mode_t'(cfg_writedata[2:1]);
            end
            if (cfg_address == REG_PERIOD) begin
                period <= cfg_writedata[PERIOD_W-1:0];
            end
        end
    end

    // Next pattern for one period step according to MODE.
    always_comb begin
        step_pat   = pattern;
        step_write = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
        step_dir   = dir;
`endif
        case (ctrl_mode)
            MODE_ROTATE: step_pat = {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
            MODE_COUNT:  step_pat = pattern + 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
            MODE_BOUNCE: begin
                if (!dir) begin
                    if (pattern[LED_WIDTH-1]) step_dir = 1'b1;
                    else                      step_pat = pattern << 1;
                end else begin
                    if (pattern[0]) step_dir = 1'b0;
                    else            step_pat = pattern >> 1;
                end
            end
`endif
            default:     step_write = 1'b0;
        endcase
    end

    // Sequencer next-state, period counter, pattern load/step and follow-up latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = per_cnt;
        pat_nxt   = pattern;
        pend_nxt  = pend;
        if (pat_wr) begin
            pat_nxt = cfg_writedata[LED_WIDTH-1:0];
        end
        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                pend_nxt = 1'b0;
                if (en_rise || (pat_wr && ctrl_en)) begin
                    state_nxt = WRITE;
                end
            end
            WAIT: begin
                if (!en_nxt) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (do_step) begin
                    cnt_nxt = '0;
                    if (!pat_wr) begin
                        pat_nxt = step_pat;
                    end
                    if (step_write) begin
                        state_nxt = WRITE;
                    end
                end else if (tick) begin
                    cnt_nxt = per_cnt + 1'b1;
                end
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    pend_nxt = 1'b0;
                    if (!en_nxt) begin
                        state_nxt = IDLE;
                    end else if (pend || pat_wr) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (pat_wr) begin
                    pend_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // Write data is captured only when a transfer starts so it stays stable under waitrequest.
    always_comb begin
        wd_nxt                 = '0;
        wd_nxt[LED_WIDTH-1:0]  = pat_nxt;
        load_wd                = (state_nxt == WRITE) && ((state != WRITE) || !m_waitrequest);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            per_cnt     <= '0;
            pattern     <= LED_WIDTH'(PATTERN_RST);
            pend        <= 1'b0;
            m_writedata <= '0;
        end else begin
            state   <= state_nxt;
            per_cnt <= cnt_nxt;
            pattern <= pat_nxt;
            pend    <= pend_nxt;
            if (load_wd) begin
                m_writedata <= wd_nxt;
            end
        end
    end

`ifdef LED_SEQ_BOUNCE_EN
    // Bounce direction; a coincident PATTERN load discards the step and its flip.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir <= 1'b0;
        end else if (do_step && !pat_wr) begin
            dir <= step_dir;
        end
    end
`endif

    assign m_address    = 2'b00;
    assign m_chipselect = (state == WRITE);
    assign m_write_n    = (state != WRITE);

    // Zero-latency register readback.
    always_comb begin
        cfg_readdata = '0;
        case (cfg_address)
            REG_CTRL:    cfg_readdata[2:0] = {ctrl_mode, ctrl_en};
            REG_PERIOD:  cfg_readdata[PERIOD_W-1:0] = period;
            REG_PATTERN: cfg_readdata[LED_WIDTH-1:0] = pattern;
            REG_STATUS: begin
                cfg_readdata[0]               = (state == WRITE);
                cfg_readdata[1]               = dir_bit;
                cfg_readdata[16 +: LED_WIDTH] = pattern;
            end
            default: cfg_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_led_sequencer.sv
// tb_soc_system_led_sequencer: directed bench for soc_system_led_sequencer
// (LED_WIDTH=10, TICK_DIV=4, PERIOD_W=16).
module tb_soc_system_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  cfg_address;
    logic        cfg_chipselect;
    logic        cfg_write_n;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;
    int          cyc    = 0;
    int          wr_cnt = 0;
    int          wr_cyc[$];
    logic [31:0] exp_q[$];

    soc_system_led_sequencer #(
        .LED_WIDTH(10),
        .TICK_DIV (4),
        .PERIOD_W (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_address   (cfg_address),
        .cfg_chipselect(cfg_chipselect),
        .cfg_write_n   (cfg_write_n),
        .cfg_writedata (cfg_writedata),
        .cfg_readdata  (cfg_readdata),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every accepted PIO write is popped against the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && m_chipselect === 1'b1 && m_write_n === 1'b0 &&
            m_waitrequest === 1'b0) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            check("write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) check("write_data", m_writedata, exp_q.pop_front());
            check("write_addr", {30'd0, m_address}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_address    = a;
        cfg_writedata  = d;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b0;
        @(posedge clk);
        #1;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_address    = a;
        cfg_chipselect = 1'b1;
        cfg_write_n    = 1'b1;
        #1;
        d = cfg_readdata;
        cfg_chipselect = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int left = budget;
        while (wr_cnt < target && left > 0) begin
            @(posedge clk);
            #1;
            left--;
        end
        check(tag, wr_cnt, target);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int base;

        reset_n        = 1'b0;
        cfg_address    = 2'd0;
        cfg_chipselect = 1'b0;
        cfg_write_n    = 1'b1;
        cfg_writedata  = '0;
        m_waitrequest  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        cfg_read(2'd0, rd); check("rst_ctrl", rd, 32'h0000_0000);
        cfg_read(2'd1, rd); check("rst_period", rd, 32'd250);
        cfg_read(2'd2, rd); check("rst_pattern", rd, 32'h0000_000F);
        cfg_read(2'd3, rd); check("rst_status", rd, 32'h000F_0000);
        check("rst_cs", {31'd0, m_chipselect}, 32'd0);
        check("rst_wn", {31'd0, m_write_n}, 32'd1);
        check("rst_wdata", m_writedata, 32'd0);

        // Rotate, PERIOD=2: writes 8 cycles apart
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'h201);
        step(4);
        check("idle_pattern_no_write", wr_cnt, 32'd0);
        base = wr_cyc.size();
        exp_q.push_back(32'h201);
        exp_q.push_back(32'h003);
        exp_q.push_back(32'h006);
        cfg_write(2'd0, 32'h3);
        wait_writes(3, 60, "rot_count");
        check("rot_gap1", wr_cyc[base+1] - wr_cyc[base], 32'd8);
        check("rot_gap2", wr_cyc[base+2] - wr_cyc[base+1], 32'd8);
        cfg_read(2'd0, rd); check("rot_ctrl", rd, 32'h3);
        cfg_write(2'd0, 32'h2);
        step(20);
        check("rot_stop", wr_cnt, 32'd3);
        cfg_read(2'd3, rd); check("rot_status", rd, 32'h0006_0000);

        // Bounce from 0x100
        do_reset();
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'h100);
        base = wr_cnt;
        exp_q.push_back(32'h100);
`ifdef LED_SEQ_BOUNCE_EN
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h100);
        cfg_write(2'd0, 32'h5);
        wait_writes(base + 4, 60, "bounce_count");
        cfg_read(2'd0, rd); check("bounce_ctrl", rd, 32'h5);
        cfg_write(2'd0, 32'h4);
        step(10);
        check("bounce_stop", wr_cnt, base + 4);
        cfg_read(2'd3, rd); check("bounce_status", rd, 32'h0100_0002);
`else
        cfg_write(2'd0, 32'h5);
        step(30);
        check("bounce_static_count", wr_cnt, base + 1);
        cfg_read(2'd0, rd); check("bounce_ctrl", rd, 32'h5);
        cfg_write(2'd0, 32'h4);
        cfg_read(2'd3, rd); check("bounce_status", rd, 32'h0100_0000);
`endif

        // Count wrap, PERIOD=0 behaves as 1
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'h3FF);
        base = wr_cyc.size();
        exp_q.push_back(32'h3FF);
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h001);
        cfg_write(2'd0, 32'h7);
        wait_writes(base + 3, 60, "count_count");
        check("count_gap", wr_cyc[base+2] - wr_cyc[base+1], 32'd4);
        cfg_write(2'd0, 32'h6);
        step(10);
        check("count_stop", wr_cnt, base + 3);

        // Stall with PATTERN write mid-stall
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'h001);
        m_waitrequest = 1'b1;
        base = wr_cyc.size();
        exp_q.push_back(32'h001);
        exp_q.push_back(32'h055);
        cfg_write(2'd0, 32'h3);
        for (int i = 0; i < 5; i++) begin
            check("stall_wdata", m_writedata, 32'h001);
            cfg_read(2'd3, rd);
            check("stall_busy", rd & 32'h1, 32'h1);
            if (i == 2) cfg_write(2'd2, 32'h055);
            else        step(1);
        end
        check("stall_no_accept", wr_cnt, base);
        m_waitrequest = 1'b0;
        wait_writes(base + 2, 20, "stall_count");
        cfg_write(2'd0, 32'h2);
        check("stall_followup_gap", wr_cyc[base+1] - wr_cyc[base], 32'd1);
        step(20);
        check("stall_single_extra", wr_cnt, base + 2);

        // Clear EN during a stalled write
        m_waitrequest = 1'b1;
        base = wr_cnt;
        exp_q.push_back(32'h055);
        cfg_write(2'd0, 32'h3);
        cfg_write(2'd0, 32'h2);
        step(2);
        check("enclr_cs_held", {31'd0, m_chipselect}, 32'd1);
        m_waitrequest = 1'b0;
        wait_writes(base + 1, 10, "enclr_count");
        check("enclr_cs_idle", {31'd0, m_chipselect}, 32'd0);
        cfg_read(2'd3, rd); check("enclr_status", rd, 32'h0055_0000);
        cfg_read(2'd0, rd); check("enclr_ctrl", rd, 32'h2);
        step(20);
        check("enclr_no_more", wr_cnt, base + 1);

        // Asynchronous reset mid-transfer
        m_waitrequest = 1'b1;
        cfg_write(2'd0, 32'h3);
        check("arst_cs_before", {31'd0, m_chipselect}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cs_drop", {31'd0, m_chipselect}, 32'd0);
        check("arst_wn", {31'd0, m_write_n}, 32'd1);
        m_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cfg_read(2'd0, rd); check("arst_ctrl", rd, 32'h0);
        cfg_read(2'd3, rd); check("arst_status", rd, 32'h000F_0000);
        step(10);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
